car_lane: RTL and testbench

CAR_LANE -- requirements
Module: car_lane

---
 rtl/frogger_pkg.sv | 6 +
 rtl/lane_tick.sv | 17 +
 rtl/car_lane.sv | 44 ++++
 tb/tb_car_lane.sv | 109 ++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// frogger_pkg: shared lane state type and rotation direction constants
package frogger_pkg;
  typedef enum logic {RUN, FROZEN} lane_state_t;
  localparam bit DIR_LEFT = 1'b0;
  localparam bit DIR_RIGHT = 1'b1;
endpackage

// File: rtl/lane_tick.sv
// lane_tick: step-period counter firing tick once every speed+1 enabled cycles
module lane_tick #(
  parameter int SPEED_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SPEED_BITS-1:0] speed,
  output logic                  tick
);
  logic [SPEED_BITS-1:0] cnt;
  assign tick = enable && cnt >= speed;
  // count up while enabled, restart on a step; >= lets a lowered speed act at once
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/car_lane.sv
// car_lane: rotating car pattern for one lane with freeze-on-hit and frog collision
module car_lane
  import frogger_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] INIT_PATTERN = 16'b0011001100110011,
  parameter bit               DIR          = DIR_RIGHT,
  parameter int               SPEED_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SPEED_BITS-1:0] speed,
  input  logic                  hit,
  input  logic [WIDTH-1:0]      frog,
  output logic [WIDTH-1:0]      pixels,
  output logic                  collide,
  output logic                  frozen
);
  lane_state_t state;
  logic tick;
  logic [WIDTH-1:0] rotated;
  lane_tick #(.SPEED_BITS(SPEED_BITS)) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable && state == RUN),
    .speed (speed),
    .tick  (tick)
  );
  assign rotated = DIR == DIR_RIGHT ? {pixels[0], pixels[WIDTH-1:1]} : {pixels[WIDTH-2:0], pixels[WIDTH-1]};
  assign collide = state == RUN && |(pixels & frog);
  // lane state machine: hit wins over a step and freezes everything until reset
  always_ff @(posedge clk)
    if (reset) begin
      state  <= RUN;
      frozen <= 1'b0;
      pixels <= INIT_PATTERN;
    end else if (state == RUN) begin
      if (hit) begin
        state  <= FROZEN;
        frozen <= 1'b1;
      end else if (tick) pixels <= rotated;
    end
endmodule

// File: tb/tb_car_lane.sv
// tb_car_lane: directed checks of car_lane rotation, timing, freeze and collision
module tb_car_lane;
  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, hit = 1'b0;
  logic [7:0] speed = '0;
  logic [15:0] frog = '0;
  logic [15:0] pixels;
  logic collide, frozen;
  logic reset_b = 1'b1;
  logic [7:0] frog_b = '0, pixels_b;
  logic collide_b, frozen_b;
  int checks = 0, failures = 0;
  logic [7:0] wrap_exp [8] = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};

  always #5 clk = ~clk;

  car_lane dut (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed), .hit(hit),
    .frog(frog), .pixels(pixels), .collide(collide), .frozen(frozen)
  );

  car_lane #(.WIDTH(8), .INIT_PATTERN(8'b00000011), .DIR(0)) dut_b (
    .clk(clk), .reset(reset_b), .enable(1'b1), .speed(8'd0), .hit(1'b0),
    .frog(frog_b), .pixels(pixels_b), .collide(collide_b), .frozen(frozen_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick();
    reset = 1'b0;
    check("reset_pixels", pixels, 16'h3333);
    check("reset_frozen", frozen, 0);
    frog = 16'h0001; #1;
    check("collide_hit", collide, 1);
    frog = 16'h0004; #1;
    check("collide_miss", collide, 0);
    frog = 16'h0000; #1;
    check("collide_zero", collide, 0);
    enable = 1'b1;
    tick(); check("s0_step1", pixels, 16'h9999);
    tick(); check("s0_step2", pixels, 16'hCCCC);
    tick(); check("s0_step3", pixels, 16'h6666);
    tick(); check("s0_step4", pixels, 16'h3333);
    speed = 8'd3;
    tick(3); check("s3_hold", pixels, 16'h3333);
    tick(); check("s3_step", pixels, 16'h9999);
    tick(2);
    enable = 1'b0;
    tick(5); check("pause_hold", pixels, 16'h9999);
    enable = 1'b1;
    tick(); check("resume_hold", pixels, 16'h9999);
    tick(); check("resume_step", pixels, 16'hCCCC);
    tick(2);
    speed = 8'd1;
    tick(); check("speed_drop", pixels, 16'h6666);
    speed = 8'd0;
    hit = 1'b1;
    tick(); check("hit_no_rotate", pixels, 16'h6666);
    check("hit_frozen", frozen, 1);
    frog = 16'h0002; #1;
    check("frozen_collide", collide, 0);
    tick(3); check("frozen_hold", pixels, 16'h6666);
    hit = 1'b0;
    tick(2); check("frozen_stay", frozen, 1);
    hit = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hit = 1'b0;
    check("rst_frz_pixels", pixels, 16'h3333);
    check("rst_frz_frozen", frozen, 0);
    check("rst_frz_collide", collide, 1);
    frog = 16'h0000;
    speed = 8'd1;
    tick(); check("rst_cnt_hold", pixels, 16'h3333);
    tick(); check("rst_cnt_step", pixels, 16'h9999);
    speed = 8'd3;
    tick(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(3); check("midrst_hold", pixels, 16'h3333);
    tick(); check("midrst_step", pixels, 16'h9999);
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    check("b_reset", pixels_b, 8'h03);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("b_rot%0d", i), pixels_b, wrap_exp[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
